fifo_rd_packer: RTL and testbench
=================================

Name: fifo_rd_packer

Overview:
Read-side consumer for the async FIFO, in the read clock domain. Pops DSIZE-bit entries from the FIFO's show-ahead read port (rdata valid whenever rempty=0) and packs PACK consecutive entries into one wide word. Presents each word on a valid/ready output stream. A flush request drains residual entries as a partial word marked with byte-keep and last.

Parameters:
DSIZE, 8, width of one FIFO entry (matches FIFO DSIZE)
PACK, 4, entries per output word; power of two, 2..16
CW, $clog2(PACK), width of the lane counter (derived localparam)

Ports:
rclk  input  1  read-domain clock
rrst  input  1  synchronous active-high reset; asserted together with the FIFO rrst_n
rempty  input  1  FIFO empty flag; registered
rdata  input  DSIZE  FIFO head entry; valid when rempty=0
rinc  output  1  pop strobe to FIFO; combinational
flush  input  1  single-cycle flush request pulse
flush_done  output  1  one-cycle pulse when a flush completes
m_valid  output  1  output word valid
m_ready  input  1  downstream accept
m_data  output  DSIZE*PACK  packed word; lane 0 = first entry, in LSBs
m_keep  output  PACK  lane-valid mask
m_last  output  1  word terminates a flush

Behaviour:
- Reset (rrst=1 at rclk edge): cnt=0, accumulator=0, m_valid=0, m_data=0, m_keep=0, m_last=0, flush_done=0, state=RUN. Partially packed entries are discarded.
- out_free = !m_valid | m_ready. The output register holds its value while m_valid & !m_ready.
- rinc = !rempty & (cnt < PACK-1 | out_free) & !(state==DRAIN & rempty). Never assert rinc while rempty=1.
- Pop at cnt<PACK-1: accumulator lane[cnt] <= rdata, cnt++.
- Pop at cnt==PACK-1: output register <= {rdata, accumulator lanes}, m_keep=all ones, m_last=0, m_valid=1, cnt=0.
- Latency: a word is presented on m_valid one cycle after the pop of its last entry. Throughput is one pop per cycle when m_ready=1.
- Back-to-back pops are legal. rempty already reflects the post-pop pointer on the next cycle.
- FSM states: RUN, DRAIN.
  - RUN -> DRAIN on flush=1. A flush arriving during DRAIN is absorbed.
  - DRAIN: normal popping continues while rempty=0.
  - DRAIN with rempty=1 and cnt==0: flush_done=1 next cycle, return to RUN, no word emitted.
  - DRAIN with rempty=1, cnt>0 and out_free: emit partial word.
    - m_data lanes >= cnt are zero; m_keep = (1<<cnt)-1; m_last=1.
    - Set cnt=0, flush_done=1 next cycle, return to RUN.
  - DRAIN with rempty=1, cnt>0 and !out_free: hold until out_free.
- A pop and a partial emit never occur in the same cycle.
- The output register only loads when out_free.
- flush and rrst in the same cycle: reset wins.
- cnt wraps only via the full-word path; cnt never reaches PACK.

Decomposition:
- Shared package fifo_pkg holds:
  - state enum typedef pk_state_e {RUN, DRAIN}
  - function keep_mask(cnt) returning the PACK-bit mask
- Single module; no sub-module. The output register stays inline with the pop logic because their enables are coupled.

Test Plan:
- Push 0x11,0x22,0x33,0x44 with m_ready=1 -> rinc high 4 consecutive cycles; one word m_data=0x44332211, m_keep=0xF, m_last=0, m_valid one cycle after the 4th pop.
- Push 8 entries 0x01..0x08 back-to-back, m_ready=1 -> rinc continuous 8 cycles; words 0x04030201 then 0x08070605.
- Push 8 entries with m_ready=0 -> 7 pops, then rinc=0 with first word held stable; raise m_ready -> 8th pop occurs in the same cycle as the handshake.
- Push 0xAA,0xBB,0xCC, then pulse flush -> m_data=0x00CCBBAA, m_keep=0x7, m_last=1, then flush_done pulse.
- Flush with FIFO empty and cnt=0 -> no m_valid; flush_done one cycle after the DRAIN evaluation.
- Push 2 entries, assert rrst for one cycle -> m_valid=0, cnt=0; next 4 pushes 0x10..0x40 produce 0x40302010 with no stale lanes.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side packer.
// Lane masks are built at the widest legal PACK and truncated by users.
package fifo_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } pk_state_e;

    localparam int MAX_PACK = 16;

    function automatic logic [MAX_PACK-1:0] keep_mask(input logic [4:0] cnt);
        keep_mask = (MAX_PACK'(1) << cnt) - MAX_PACK'(1);
    endfunction

endpackage

// File: rtl/fifo_rd_packer.sv
// Pops a show-ahead FIFO and packs PACK entries per output word.
// A flush drains any residual lanes as a keep-masked last word.
module fifo_rd_packer #(
    parameter int DSIZE = 8,
    parameter int PACK  = 4
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  rempty,
    input  logic [DSIZE-1:0]      rdata,
    output logic                  rinc,
    input  logic                  flush,
    output logic                  flush_done,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DSIZE*PACK-1:0] m_data,
    output logic [PACK-1:0]       m_keep,
    output logic                  m_last
);
    import fifo_pkg::*;

    localparam int CW = $clog2(PACK);
    localparam int W  = DSIZE * PACK;

    logic [CW-1:0]   cnt;
    logic [W-1:0]    acc;
    pk_state_e       state;
    logic            out_free;
    logic            last_lane;
    logic            drain_empty;
    logic [PACK-1:0] part_keep;
    logic [W-1:0]    part_data;

    assign out_free    = !m_valid || m_ready;
    assign last_lane   = cnt == CW'(PACK - 1);
    assign drain_empty = (state == DRAIN) && rempty;
    assign rinc        = !rempty && (!last_lane || out_free) && !drain_empty;
    assign part_keep   = PACK'(keep_mask(5'(cnt)));

    // Stale accumulator lanes beyond cnt must never leak into a partial word.
    always_comb begin
        part_data = '0;
        for (int i = 0; i < PACK; i++) begin
            if (part_keep[i]) begin
                part_data[i*DSIZE +: DSIZE] = acc[i*DSIZE +: DSIZE];
            end
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            cnt        <= '0;
            acc        <= '0;
            state      <= RUN;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_keep     <= '0;
            m_last     <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            if (rinc) begin
                if (last_lane) begin
                    m_data  <= {rdata, acc[W-DSIZE-1:0]};
                    m_keep  <= '1;
                    m_last  <= 1'b0;
                    m_valid <= 1'b1;
                    cnt     <= '0;
                end else begin
                    acc[cnt*DSIZE +: DSIZE] <= rdata;
                    cnt <= cnt + CW'(1);
                end
            end
            unique case (state)
                RUN: begin
                    if (flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (rempty) begin
                        if (cnt == '0) begin
                            flush_done <= 1'b1;
                            state      <= RUN;
                        end else if (out_free) begin
                            m_data     <= part_data;
                            m_keep     <= part_keep;
                            m_last     <= 1'b1;
                            m_valid    <= 1'b1;
                            cnt        <= '0;
                            flush_done <= 1'b1;
                            state      <= RUN;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: queue-modelled FIFO, scoreboarded output words.
module tb_fifo_rd_packer;

    localparam int DSIZE = 8;
    localparam int PACK  = 4;

    logic        rclk    = 1'b0;
    logic        rrst    = 1'b1;
    logic        rempty  = 1'b1;
    logic [7:0]  rdata   = 8'h00;
    logic        flush   = 1'b0;
    logic        m_ready = 1'b0;
    logic        rinc;
    logic        flush_done;
    logic        m_valid;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] fq[$];
    int         tests   = 0;
    int         fails   = 0;
    int         fd_seen = 0;
    int         fd_exp  = 0;

    fifo_rd_packer #(.DSIZE(DSIZE), .PACK(PACK)) dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .rempty     (rempty),
        .rdata      (rdata),
        .rinc       (rinc),
        .flush      (flush),
        .flush_done (flush_done),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_keep     (m_keep),
        .m_last     (m_last)
    );

    always #5 rclk = ~rclk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic refresh();
        rempty = (fq.size() == 0);
        rdata  = rempty ? 8'h00 : fq[0];
    endtask

    task automatic push(input logic [7:0] v);
        fq.push_back(v);
        refresh();
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] k,
                               input logic l);
        exp_t e;
        e.d = d;
        e.k = k;
        e.l = l;
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge rclk);
        #2;
    endtask

    task automatic neg();
        @(negedge rclk);
    endtask

    // FIFO model: pop decision sampled mid-cycle, applied just after the edge.
    initial begin
        logic pop_s;
        logic rst_s;
        forever begin
            @(negedge rclk);
            pop_s = rinc;
            rst_s = rrst;
            @(posedge rclk);
            #1;
            if (rst_s) begin
                fq.delete();
            end else if (pop_s && fq.size() > 0) begin
                void'(fq.pop_front());
            end
            refresh();
        end
    end

    // Monitor: compares every accepted word against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge rclk);
            if (!rrst) begin
                if (rinc && rempty) begin
                    tests++;
                    fails++;
                    $display("FAIL rinc_on_empty: got rinc=1 expected 0");
                end
                if (flush_done) fd_seen++;
                if (m_valid && m_ready) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_word: got %h expected none",
                                 m_data);
                    end else begin
                        e = sb.pop_front();
                        check("word_data", m_data, e.d);
                        check("word_keep", 32'(m_keep), 32'(e.k));
                        check("word_last", 32'(m_last), 32'(e.l));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) cyc();
        neg();
        check("rst_valid", 32'(m_valid), 0);
        check("rst_data", m_data, 0);
        check("rst_keep", 32'(m_keep), 0);
        check("rst_last", 32'(m_last), 0);
        check("rst_fdone", 32'(flush_done), 0);
        check("rst_rinc", 32'(rinc), 0);
        cyc();
        rrst = 1'b0;

        // full word, latency
        cyc();
        m_ready = 1'b1;
        expect_word(32'h44332211, 4'hF, 1'b0);
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        for (int i = 0; i < 4; i++) begin
            neg();
            check("t1_rinc", 32'(rinc), 1);
        end
        neg();
        check("t1_valid", 32'(m_valid), 1);
        check("t1_rinc_idle", 32'(rinc), 0);

        // back-to-back words
        cyc();
        expect_word(32'h04030201, 4'hF, 1'b0);
        expect_word(32'h08070605, 4'hF, 1'b0);
        for (int v = 1; v <= 8; v++) push(8'(v));
        for (int i = 0; i < 8; i++) begin
            neg();
            check("t2_rinc", 32'(rinc), 1);
        end
        repeat (3) cyc();

        // backpressure
        m_ready = 1'b0;
        expect_word(32'h84838281, 4'hF, 1'b0);
        expect_word(32'h88878685, 4'hF, 1'b0);
        for (int v = 8'h81; v <= 8'h88; v++) push(8'(v));
        repeat (10) cyc();
        neg();
        check("t3_stall_rinc", 32'(rinc), 0);
        check("t3_hold_valid", 32'(m_valid), 1);
        check("t3_hold_data", m_data, 32'h84838281);
        check("t3_fifo_left", 32'(fq.size()), 1);
        cyc();
        m_ready = 1'b1;
        neg();
        check("t3_pop_on_hs", 32'(rinc), 1);
        repeat (3) cyc();

        // partial flush
        expect_word(32'h00CCBBAA, 4'h7, 1'b1);
        fd_exp++;
        push(8'hAA); push(8'hBB); push(8'hCC);
        repeat (4) cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        neg();
        check("t4_no_early", 32'(m_valid), 0);
        neg();
        check("t4_fdone", 32'(flush_done), 1);
        check("t4_last", 32'(m_last), 1);
        neg();
        check("t4_fdone_pulse", 32'(flush_done), 0);

        // empty flush
        cyc();
        flush = 1'b1;
        fd_exp++;
        cyc();
        flush = 1'b0;
        neg();
        check("t5_fdone_early", 32'(flush_done), 0);
        neg();
        check("t5_fdone", 32'(flush_done), 1);
        check("t5_no_word", 32'(m_valid), 0);
        neg();
        check("t5_fdone_pulse", 32'(flush_done), 0);

        // reset discards partial lanes
        cyc();
        push(8'h55); push(8'h66);
        repeat (3) cyc();
        rrst = 1'b1;
        cyc();
        rrst = 1'b0;
        neg();
        check("t6_rst_valid", 32'(m_valid), 0);
        cyc();
        expect_word(32'h40302010, 4'hF, 1'b0);
        push(8'h10); push(8'h20); push(8'h30); push(8'h40);
        repeat (6) cyc();

        check("sb_empty", 32'(sb.size()), 0);
        check("fdone_count", fd_seen, fd_exp);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
